// File: rtl/alien_fleet.sv
// alien_fleet: N_ROWS x N_COLS invader formation that marches, descends, takes rocket hits and picks shooters round-robin.
// Optional macro SPEEDUP_EN: the fleet moves only on every k-th tick, k = number of aliens alive.
module alien_fleet #(
    parameter int N_COLS    = 4,
    parameter int N_ROWS    = 2,
    parameter int START_X   = 30,
    parameter int START_Y   = 50,
    parameter int COL_PITCH = 30,
    parameter int ROW_PITCH = 50,
    parameter int HALF_W    = 20,
    parameter int HALF_H    = 10,
    parameter int STEP_X    = 2,
    parameter int STEP_DOWN = 10,
    parameter int X_MIN     = 0,
    parameter int X_MAX     = 639,
    parameter int FLOOR_Y   = 440,
    localparam int N        = N_ROWS * N_COLS,
    localparam int IW       = (N > 1) ? $clog2(N) : 1
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          playing,
    input  logic          tick,
    input  logic          shiprocket,
    input  logic [9:0]    shiprocketX,
    input  logic [8:0]    shiprocketY,
    input  logic          fire_req,
    output logic [N-1:0]  alive,
    output logic [9:0]    fleetX,
    output logic [8:0]    fleetY,
    output logic          direction,
    output logic          hit,
    output logic [IW-1:0] hit_index,
    output logic          fire_valid,
    output logic [9:0]    fireX,
    output logic [8:0]    fireY,
    output logic          cleared,
    output logic          landed
);
    typedef enum logic [1:0] {IDLE, MARCH, CLEARED, LANDED} state_t;
    state_t state, state_next;

    // Geometry is evaluated at 16 bits so no sum or bound can wrap.
    localparam logic [15:0] CP       = 16'(COL_PITCH);
    localparam logic [15:0] RP       = 16'(ROW_PITCH);
    localparam logic [15:0] HW       = 16'(HALF_W);
    localparam logic [15:0] HH       = 16'(HALF_H);
    localparam logic [15:0] SX       = 16'(STEP_X);
    localparam logic [15:0] XMAX     = 16'(X_MAX);
    localparam logic [15:0] LEFT_LIM = 16'(X_MIN + HALF_W + STEP_X);
    localparam logic [15:0] FLOOR    = 16'(FLOOR_Y);

    logic              scanning;
    logic [IW-1:0]     scan_idx, scan_cnt, fire_ptr, scan_nxt;
    logic [15:0]       fx, fy, rx, ry, cx, cy, sx, sy, lcol, rcol;
    logic [N_COLS-1:0] col_alive;
    logic              any_alive, floor_hit, hit_any, at_edge, move;
    logic [IW-1:0]     hit_sel;

    assign fx        = 16'(fleetX);
    assign fy        = 16'(fleetY);
    assign rx        = 16'(shiprocketX);
    assign ry        = 16'(shiprocketY);
    assign any_alive = |alive;
    assign scan_nxt  = (scan_idx == IW'(N - 1)) ? '0 : scan_idx + IW'(1);

    // Descending walk so the lowest matching index is the last one written.
    always_comb begin
        col_alive = '0;
        cx        = '0;
        cy        = '0;
        sx        = '0;
        sy        = '0;
        lcol      = '0;
        rcol      = '0;
        floor_hit = 1'b0;
        hit_any   = 1'b0;
        hit_sel   = '0;
        for (int r = N_ROWS - 1; r >= 0; r--) begin
            for (int c = N_COLS - 1; c >= 0; c--) begin
                cx = fx + 16'(c) * CP;
                cy = fy + 16'(r) * RP;
                if (alive[r*N_COLS+c]) begin
                    col_alive[c] = 1'b1;
                    if (cy + HH >= FLOOR) floor_hit = 1'b1;
                    if (shiprocket && (rx + HW >= cx) && (rx <= cx + HW) &&
                        (ry + HH >= cy) && (ry <= cy + HH)) begin
                        hit_any = 1'b1;
                        hit_sel = IW'(r*N_COLS + c);
                    end
                end
                if (scan_idx == IW'(r*N_COLS + c)) begin
                    sx = cx;
                    sy = cy + HH;
                end
            end
        end
        for (int c = N_COLS - 1; c >= 0; c--) if (col_alive[c]) lcol = 16'(c);
        for (int c = 0; c < N_COLS; c++)      if (col_alive[c]) rcol = 16'(c);
        at_edge = direction ? (fx + rcol * CP + HW + SX > XMAX)
                            : (fx + lcol * CP < LEFT_LIM);
    end

`ifdef SPEEDUP_EN
    logic [IW:0] tick_cnt, kcount;

    always_comb begin
        kcount = '0;
        for (int i = 0; i < N; i++) kcount = kcount + (IW+1)'(alive[i]);
    end

    assign move = tick && (tick_cnt + (IW+1)'(1) >= kcount);

    always_ff @(posedge clk or posedge reset) begin
        if (reset)                            tick_cnt <= '0;
        else if (state != MARCH || !playing)  tick_cnt <= '0;
        else if (tick)                        tick_cnt <= move ? '0 : tick_cnt + (IW+1)'(1);
    end
`else
    assign move = tick;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    always_comb begin
        state_next = state;
        cleared    = 1'b0;
        landed     = 1'b0;
        case (state)
            IDLE:    if (playing) state_next = MARCH;
            MARCH: begin
                if (!playing)        state_next = IDLE;
                else if (!any_alive) state_next = CLEARED;
                else if (floor_hit)  state_next = LANDED;
            end
            CLEARED: begin
                cleared = 1'b1;
                if (!playing) state_next = IDLE;
            end
            LANDED: begin
                landed = 1'b1;
                if (!playing) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            alive      <= '1;
            fleetX     <= 10'(START_X);
            fleetY     <= 9'(START_Y);
            direction  <= 1'b1;
            hit        <= 1'b0;
            hit_index  <= '0;
            fire_valid <= 1'b0;
            fireX      <= '0;
            fireY      <= '0;
            scanning   <= 1'b0;
            scan_idx   <= '0;
            scan_cnt   <= '0;
            fire_ptr   <= '0;
        end else begin
            hit        <= 1'b0;
            fire_valid <= 1'b0;
            if (state == IDLE || !playing) begin
                alive     <= '1;
                fleetX    <= 10'(START_X);
                fleetY    <= 9'(START_Y);
                direction <= 1'b1;
                scanning  <= 1'b0;
                scan_idx  <= '0;
                scan_cnt  <= '0;
                fire_ptr  <= '0;
            end else if (state == MARCH) begin
                if (move && any_alive) begin
                    if (at_edge) begin
                        fleetY    <= fleetY + 9'(STEP_DOWN);
                        direction <= ~direction;
                    end else if (direction) begin
                        fleetX <= fleetX + 10'(STEP_X);
                    end else begin
                        fleetX <= fleetX - 10'(STEP_X);
                    end
                end
                if (hit_any) begin
                    alive[hit_sel] <= 1'b0;
                    hit            <= 1'b1;
                    hit_index      <= hit_sel;
                end
                // Shooter eligibility uses the pre-edge bitmap, so a same-cycle kill still fires.
                if (scanning) begin
                    if (alive[scan_idx]) begin
                        fire_valid <= 1'b1;
                        fireX      <= sx[9:0];
                        fireY      <= sy[8:0];
                        fire_ptr   <= scan_nxt;
                        scanning   <= 1'b0;
                    end else begin
                        scan_idx <= scan_nxt;
                        if (scan_cnt == IW'(N - 1)) scanning <= 1'b0;
                        else                        scan_cnt <= scan_cnt + IW'(1);
                    end
                end else if (fire_req) begin
                    scanning <= 1'b1;
                    scan_idx <= fire_ptr;
                    scan_cnt <= '0;
                end
            end else begin
                scanning <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_alien_fleet.sv
// Bench for alien_fleet (default build): directed scenarios plus randomized play against a cycle-level game model.
module tb_alien_fleet;
    localparam int ST_IDLE = 0, ST_MARCH = 1, ST_CLEARED = 2, ST_LANDED = 3;

    logic       clk = 1'b0, reset = 1'b1, playing = 1'b0, tick = 1'b0;
    logic       shiprocket = 1'b0, fire_req = 1'b0;
    logic [9:0] shiprocketX = '0;
    logic [8:0] shiprocketY = '0;
    logic [7:0] alive;
    logic [9:0] fleetX, fireX;
    logic [8:0] fleetY, fireY;
    logic       direction, hit, fire_valid, cleared, landed;
    logic [2:0] hit_index;

    int checks = 0, errors = 0;

    // Reference game state
    int         m_st, m_fx, m_fy, m_hidx, m_fxo, m_fyo, m_ptr, m_sbase, m_sage;
    logic [7:0] m_alive;
    bit         m_dir, m_hit, m_fv, m_scan;

    always #5 clk = ~clk;

    alien_fleet dut (
        .clk(clk), .reset(reset), .playing(playing), .tick(tick),
        .shiprocket(shiprocket), .shiprocketX(shiprocketX), .shiprocketY(shiprocketY),
        .fire_req(fire_req), .alive(alive), .fleetX(fleetX), .fleetY(fleetY),
        .direction(direction), .hit(hit), .hit_index(hit_index),
        .fire_valid(fire_valid), .fireX(fireX), .fireY(fireY),
        .cleared(cleared), .landed(landed)
    );

    function automatic int iabs(input int v);
        return (v < 0) ? -v : v;
    endfunction

    task automatic model_reset();
        m_st = ST_IDLE; m_alive = 8'hFF; m_fx = 30; m_fy = 50; m_dir = 1'b1;
        m_hit = 1'b0; m_hidx = 0; m_fv = 1'b0; m_fxo = 0; m_fyo = 0;
        m_ptr = 0; m_scan = 1'b0; m_sbase = 0; m_sage = 0;
    endtask

    // One clock edge of the game rules, evaluated on pre-edge state and inputs.
    task automatic model_edge();
        int         ps = m_st, pfx = m_fx, pfy = m_fy;
        logic [7:0] pa = m_alive;
        bit         pdir = m_dir;
        int         lc = 99, rc = -1, found = -1, idx;
        int         rx = int'(shiprocketX), ry = int'(shiprocketY);
        m_hit = 1'b0;
        m_fv  = 1'b0;
        if (ps == ST_IDLE || !playing) begin
            m_alive = 8'hFF; m_fx = 30; m_fy = 50; m_dir = 1'b1; m_scan = 1'b0; m_ptr = 0;
            m_st = (ps == ST_IDLE && playing) ? ST_MARCH : ST_IDLE;
        end else if (ps != ST_MARCH) begin
            m_scan = 1'b0;
        end else begin
            if (pa == 8'h00) m_st = ST_CLEARED;
            else for (int i = 0; i < 8; i++)
                if (pa[i] && pfy + (i / 4) * 50 + 10 >= 440) m_st = ST_LANDED;
            for (int i = 0; i < 8; i++)
                if (pa[i]) begin
                    if (i % 4 < lc) lc = i % 4;
                    if (i % 4 > rc) rc = i % 4;
                end
            if (tick && pa != 8'h00) begin
                if (pdir ? (pfx + rc * 30 + 20 + 2 > 639) : (pfx + lc * 30 - 20 - 2 < 0)) begin
                    m_fy  = pfy + 10;
                    m_dir = !pdir;
                end else begin
                    m_fx = pdir ? pfx + 2 : pfx - 2;
                end
            end
            if (shiprocket)
                for (int i = 0; i < 8 && found < 0; i++)
                    if (pa[i] && iabs(rx - (pfx + (i % 4) * 30)) <= 20 &&
                        iabs(ry - (pfy + (i / 4) * 50)) <= 10) found = i;
            if (found >= 0) begin
                m_alive[found] = 1'b0; m_hit = 1'b1; m_hidx = found;
            end
            if (m_scan) begin
                idx = (m_sbase + m_sage) % 8;
                if (pa[idx]) begin
                    m_fv = 1'b1; m_fxo = pfx + (idx % 4) * 30; m_fyo = pfy + (idx / 4) * 50 + 10;
                    m_ptr = (idx + 1) % 8; m_scan = 1'b0;
                end else begin
                    m_sage++;
                    if (m_sage == 8) m_scan = 1'b0;
                end
            end else if (fire_req) begin
                m_scan = 1'b1; m_sbase = m_ptr; m_sage = 0;
            end
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic restart();
        tick = 0; shiprocket = 0; fire_req = 0;
        playing = 0; cycle();
        playing = 1; cycle();
    endtask

    task automatic kill(input int i);
        shiprocket  = 1;
        shiprocketX = 10'(m_fx + (i % 4) * 30);
        shiprocketY = 9'(m_fy + (i / 4) * 50);
        cycle();
        shiprocket = 0;
    endtask

    task automatic test_reset();
        reset = 1;
        repeat (2) @(posedge clk);
        #1;
        model_reset();
        checks++; if (alive !== 8'hFF) begin errors++; $display("FAIL reset_alive: got %h want ff", alive); end
        checks++; if (fleetX !== 10'd30 || fleetY !== 9'd50) begin errors++; $display("FAIL reset_origin: got %0d,%0d want 30,50", fleetX, fleetY); end
        checks++; if (direction !== 1'b1) begin errors++; $display("FAIL reset_dir: got %b want 1", direction); end
        checks++; if ({hit, fire_valid, cleared, landed} !== 4'b0) begin errors++; $display("FAIL reset_flags: got %b want 0000", {hit, fire_valid, cleared, landed}); end
        checks++; if (hit_index !== 3'd0 || fireX !== 10'd0 || fireY !== 9'd0) begin errors++; $display("FAIL reset_regs: got %0d %0d %0d want 0 0 0", hit_index, fireX, fireY); end
        reset = 0;
    endtask

    task automatic test_first_tick();
        playing = 1; cycle();
        tick = 1; cycle(); tick = 0;
        checks++; if (fleetX !== 10'd32 || fleetY !== 9'd50) begin errors++; $display("FAIL first_tick_origin: got %0d,%0d want 32,50", fleetX, fleetY); end
        checks++; if (alive !== 8'hFF) begin errors++; $display("FAIL first_tick_alive: got %h want ff", alive); end
    endtask

    task automatic test_march_edge();
        bit reached = 0;
        tick = 1;
        for (int k = 0; k < 400 && !reached; k++) begin
            cycle();
            checks++; if (fleetX !== 10'(m_fx)) begin errors++; $display("FAIL march_x: got %0d want %0d", fleetX, m_fx); end
            if (!m_dir) reached = 1;
        end
        tick = 0;
        checks++; if (!reached) begin errors++; $display("FAIL march_budget: got no descent want descent"); end
        checks++; if (fleetY !== 9'd60 || direction !== 1'b0) begin errors++; $display("FAIL edge_descend: got y=%0d dir=%b want 60 0", fleetY, direction); end
        checks++; if (fleetX !== 10'd528) begin errors++; $display("FAIL edge_x_hold: got %0d want 528", fleetX); end
    endtask

    task automatic test_hit();
        restart();
        shiprocket = 1; shiprocketX = 10'd60; shiprocketY = 9'd50;
        cycle(); shiprocket = 0;
        checks++; if (hit !== 1'b1 || hit_index !== 3'd1) begin errors++; $display("FAIL hit_pulse: got %b idx %0d want 1 idx 1", hit, hit_index); end
        checks++; if (alive !== 8'hFD) begin errors++; $display("FAIL hit_alive: got %h want fd", alive); end
        cycle();
        checks++; if (hit !== 1'b0) begin errors++; $display("FAIL hit_one_cycle: got %b want 0", hit); end
    endtask

    task automatic test_double_hit();
        restart();
        shiprocket = 1; shiprocketX = 10'd45; shiprocketY = 9'd50;
        cycle(); shiprocket = 0;
        checks++; if (hit !== 1'b1 || hit_index !== 3'd0) begin errors++; $display("FAIL double_idx: got %b idx %0d want 1 idx 0", hit, hit_index); end
        checks++; if (alive !== 8'hFE) begin errors++; $display("FAIL double_alive: got %h want fe", alive); end
    endtask

    task automatic test_fire();
        int lat = 0;
        restart();
        for (int i = 0; i < 7; i++) begin
            kill(i);
            checks++; if (hit_index !== 3'(i)) begin errors++; $display("FAIL kill_idx: got %0d want %0d", hit_index, i); end
        end
        checks++; if (alive !== 8'h80) begin errors++; $display("FAIL fire_setup: got %h want 80", alive); end
        fire_req = 1; cycle(); fire_req = 0;
        for (int k = 1; k <= 10 && lat == 0; k++) begin
            cycle();
            if (fire_valid === 1'b1) lat = k;
        end
        checks++; if (lat < 1 || lat > 8) begin errors++; $display("FAIL fire_latency: got %0d want 1..8", lat); end
        checks++; if (fireX !== 10'd120 || fireY !== 9'd110) begin errors++; $display("FAIL fire_pos: got %0d,%0d want 120,110", fireX, fireY); end
        cycle();
        checks++; if (fire_valid !== 1'b0) begin errors++; $display("FAIL fire_one_cycle: got %b want 0", fire_valid); end
    endtask

    task automatic test_clear();
        kill(7);
        checks++; if (alive !== 8'h00) begin errors++; $display("FAIL clear_alive: got %h want 00", alive); end
        cycle();
        checks++; if (cleared !== 1'b1 || landed !== 1'b0) begin errors++; $display("FAIL cleared_flag: got %b%b want 10", cleared, landed); end
        playing = 0; cycle();
        checks++; if (cleared !== 1'b0 || alive !== 8'hFF || fleetX !== 10'd30) begin errors++; $display("FAIL clear_reload: got %b %h %0d want 0 ff 30", cleared, alive, fleetX); end
    endtask

    task automatic test_landed();
        int held;
        restart();
        tick = 1;
        for (int k = 0; k < 12000 && m_st != ST_LANDED; k++) begin
            cycle();
            checks++; if (landed !== (m_st == ST_LANDED)) begin errors++; $display("FAIL landed_level: got %b want %b", landed, m_st == ST_LANDED); end
        end
        checks++; if (landed !== 1'b1 || fleetY !== 9'd380) begin errors++; $display("FAIL landed_final: got %b y=%0d want 1 y=380", landed, fleetY); end
        held = m_fx;
        repeat (5) cycle();
        tick = 0;
        checks++; if (fleetX !== 10'(held) || landed !== 1'b1) begin errors++; $display("FAIL landed_hold: got %0d %b want %0d 1", fleetX, landed, held); end
    endtask

    task automatic test_random();
        int tgt, x, y;
        restart();
        for (int n = 0; n < 3000; n++) begin
            playing    = ($urandom_range(0, 199) != 0);
            tick       = 1'($urandom_range(0, 1));
            fire_req   = ($urandom_range(0, 4) == 0);
            shiprocket = ($urandom_range(0, 2) == 0);
            tgt = int'($urandom_range(0, 7));
            x = m_fx + (tgt % 4) * 30 + int'($urandom_range(0, 60)) - 30;
            y = m_fy + (tgt / 4) * 50 + int'($urandom_range(0, 30)) - 15;
            shiprocketX = 10'((x < 0) ? 0 : x);
            shiprocketY = 9'((y < 0) ? 0 : y);
            cycle();
            checks++; if (alive !== m_alive) begin errors++; $display("FAIL rnd_alive: got %h want %h", alive, m_alive); end
            checks++; if (fleetX !== 10'(m_fx) || fleetY !== 9'(m_fy) || direction !== m_dir) begin errors++; $display("FAIL rnd_origin: got %0d,%0d,%b want %0d,%0d,%b", fleetX, fleetY, direction, m_fx, m_fy, m_dir); end
            checks++; if (hit !== m_hit || hit_index !== 3'(m_hidx)) begin errors++; $display("FAIL rnd_hit: got %b/%0d want %b/%0d", hit, hit_index, m_hit, m_hidx); end
            checks++; if (fire_valid !== m_fv || fireX !== 10'(m_fxo) || fireY !== 9'(m_fyo)) begin errors++; $display("FAIL rnd_fire: got %b %0d,%0d want %b %0d,%0d", fire_valid, fireX, fireY, m_fv, m_fxo, m_fyo); end
            checks++; if (cleared !== (m_st == ST_CLEARED) || landed !== (m_st == ST_LANDED)) begin errors++; $display("FAIL rnd_flags: got %b%b want %b%b", cleared, landed, m_st == ST_CLEARED, m_st == ST_LANDED); end
        end
        tick = 0; fire_req = 0; shiprocket = 0;
    endtask

    task automatic test_reset_mid_scan();
        restart();
        for (int i = 0; i < 7; i++) kill(i);
        fire_req = 1; cycle(); fire_req = 0;
        cycle(); cycle();
        #2 reset = 1;
        #1;
        model_reset();
        checks++; if (fire_valid !== 1'b0 || hit !== 1'b0) begin errors++; $display("FAIL midscan_pulses: got %b%b want 00", fire_valid, hit); end
        checks++; if (alive !== 8'hFF || fleetX !== 10'd30 || fleetY !== 9'd50 || direction !== 1'b1) begin errors++; $display("FAIL midscan_state: got %h %0d %0d %b want ff 30 50 1", alive, fleetX, fleetY, direction); end
        checks++; if (hit_index !== 3'd0 || fireX !== 10'd0 || fireY !== 9'd0) begin errors++; $display("FAIL midscan_regs: got %0d %0d %0d want 0 0 0", hit_index, fireX, fireY); end
        for (int k = 0; k < 10; k++) begin
            @(posedge clk); #1;
            checks++; if (fire_valid !== 1'b0) begin errors++; $display("FAIL midscan_quiet: got %b want 0", fire_valid); end
        end
        reset = 0;
    endtask

    initial begin
        model_reset();
        test_reset();
        test_first_tick();
        test_march_edge();
        test_hit();
        test_double_hit();
        test_fire();
        test_clear();
        test_landed();
        test_random();
        test_reset_mid_scan();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
